// File: rtl/audio_sample_mixer.sv
// Audio back-end: per-channel stability filter, signed conversion, attenuation, L/R routing, saturating mix.
// Optional peak meters (peak_l/peak_r/peak_clr) are compiled in when AUDIO_PEAK_EN is defined.

module audio_sample_mixer #(
  parameter int CHANNELS   = 2,
  parameter int IN_W       = 11,
  parameter int OUT_W      = 16,
  parameter int STABLE_CNT = 2,
  parameter int SIGNED_IN  = 0
) (
  input  logic                      clk_audio,
  input  logic                      reset_n,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic [CHANNELS-1:0]       route_l,
  input  logic [CHANNELS-1:0]       route_r,
  input  logic [2*CHANNELS-1:0]     atten,
  input  logic                      mute,
  output logic signed [OUT_W-1:0]   audio_l,
  output logic signed [OUT_W-1:0]   audio_r,
  output logic                      sample_stb,
  output logic                      sat_flag
`ifdef AUDIO_PEAK_EN
  ,
  input  logic                      peak_clr,
  output logic [OUT_W-2:0]          peak_l,
  output logic [OUT_W-2:0]          peak_r
`endif
);

  localparam int ACC_W = OUT_W + 3;
  localparam int SHIFT = OUT_W - IN_W;

  localparam logic [IN_W-1:0]         MSB_MASK = IN_W'(1) << (IN_W - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = $signed({4'b0000, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] ACC_MIN  = $signed({4'b1111, {(OUT_W-1){1'b0}}});
  localparam logic signed [OUT_W-1:0] OUT_MAX  = $signed({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [OUT_W-1:0] OUT_MIN  = $signed({1'b1, {(OUT_W-1){1'b0}}});

  logic [CHANNELS-1:0]        w_upd;
  logic signed [ACC_W-1:0]    w_conv [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [IN_W-1:0]         r_sh [STABLE_CNT];
    logic [IN_W-1:0]         r_held;
    logic                    r_upd;
    logic                    w_steady;
    logic                    w_accept;
    logic [IN_W-1:0]         w_fix;
    logic signed [OUT_W-1:0] w_just;
    logic signed [OUT_W-1:0] w_att;

    always_comb begin
      w_steady = 1'b1;
      for (int j = 1; j < STABLE_CNT; j++) begin
        if (r_sh[j] != r_sh[0]) w_steady = 1'b0;
      end
    end

    assign w_accept = w_steady && (r_sh[STABLE_CNT-1] != r_held);

    always_ff @(posedge clk_audio) begin
      if (!reset_n) begin
        for (int j = 0; j < STABLE_CNT; j++) r_sh[j] <= '0;
        r_held <= '0;
        r_upd  <= 1'b0;
      end else begin
        r_sh[0] <= in_data[gi*IN_W +: IN_W];
        for (int j = 1; j < STABLE_CNT; j++) r_sh[j] <= r_sh[j-1];
        r_upd <= w_accept;
        if (w_accept) r_held <= r_sh[STABLE_CNT-1];
      end
    end

    // Offset-binary becomes two's complement by flipping the MSB.
    assign w_fix  = (SIGNED_IN != 0) ? r_held : (r_held ^ MSB_MASK);
    assign w_just = $signed(OUT_W'(w_fix) << SHIFT);
    assign w_att  = w_just >>> atten[2*gi +: 2];

    assign w_conv[gi] = $signed({{3{w_att[OUT_W-1]}}, w_att});
    assign w_upd[gi]  = r_upd;
  end

  logic signed [ACC_W-1:0] w_sum_l;
  logic signed [ACC_W-1:0] w_sum_r;

  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (route_l[k]) w_sum_l = w_sum_l + w_conv[k];
      if (route_r[k]) w_sum_r = w_sum_r + w_conv[k];
    end
  end

  // Stage A tracks the mix every cycle; valid marks cycles carrying a freshly accepted sample.
  logic signed [ACC_W-1:0] r_sum_l;
  logic signed [ACC_W-1:0] r_sum_r;
  logic                    r_valid;

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      r_sum_l <= '0;
      r_sum_r <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sum_l <= w_sum_l;
      r_sum_r <= w_sum_r;
      r_valid <= |w_upd;
    end
  end

  logic                    w_hi_l, w_lo_l, w_hi_r, w_lo_r;
  logic signed [OUT_W-1:0] w_sat_l;
  logic signed [OUT_W-1:0] w_sat_r;

  assign w_hi_l  = r_sum_l > ACC_MAX;
  assign w_lo_l  = r_sum_l < ACC_MIN;
  assign w_hi_r  = r_sum_r > ACC_MAX;
  assign w_lo_r  = r_sum_r < ACC_MIN;
  assign w_sat_l = w_hi_l ? OUT_MAX : (w_lo_l ? OUT_MIN : r_sum_l[OUT_W-1:0]);
  assign w_sat_r = w_hi_r ? OUT_MAX : (w_lo_r ? OUT_MIN : r_sum_r[OUT_W-1:0]);

  // Stage B: a mute release reloads the live stage A sums even without a new sample.
  logic r_mute_d;
  logic w_mute_edge;
  logic w_load;

  assign w_mute_edge = mute && !r_mute_d;
  assign w_load      = !mute && (r_valid || r_mute_d);

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      r_mute_d   <= 1'b0;
      audio_l    <= '0;
      audio_r    <= '0;
      sample_stb <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      r_mute_d   <= mute;
      sample_stb <= w_mute_edge || w_load;
      if (mute) begin
        audio_l <= '0;
        audio_r <= '0;
      end else if (w_load) begin
        audio_l <= w_sat_l;
        audio_r <= w_sat_r;
        if (w_hi_l || w_lo_l || w_hi_r || w_lo_r) sat_flag <= 1'b1;
      end
    end
  end

`ifdef AUDIO_PEAK_EN
  function automatic logic [OUT_W-2:0] f_mag(input logic signed [OUT_W-1:0] a);
    logic signed [OUT_W-1:0] neg;
    neg = -a;
    if (a == OUT_MIN)    return {(OUT_W-1){1'b1}};
    else if (a[OUT_W-1]) return neg[OUT_W-2:0];
    else                 return a[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] w_mag_l;
  logic [OUT_W-2:0] w_mag_r;

  assign w_mag_l = f_mag(audio_l);
  assign w_mag_r = f_mag(audio_r);

  always_ff @(posedge clk_audio) begin
    if (!reset_n) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (peak_clr) begin
      peak_l <= w_mag_l;
      peak_r <= w_mag_r;
    end else begin
      if (w_mag_l > peak_l) peak_l <= w_mag_l;
      if (w_mag_r > peak_r) peak_r <= w_mag_r;
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_mixer.sv
// Bench for audio_sample_mixer (default parameters): directed test-plan cases, then random stimulus
// checked every cycle against an integer-arithmetic model of accept/convert/mix/saturate timing.

module tb_audio_sample_mixer;
  localparam int CH  = 2;
  localparam int IW  = 11;
  localparam int OW  = 16;
  localparam int SC  = 2;
  localparam int SIN = 0;

  logic                 clk_audio = 1'b0;
  logic                 reset_n;
  logic [CH*IW-1:0]     in_data;
  logic [CH-1:0]        route_l, route_r;
  logic [2*CH-1:0]      atten;
  logic                 mute;
  logic signed [OW-1:0] audio_l, audio_r;
  logic                 sample_stb, sat_flag;

  audio_sample_mixer #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .STABLE_CNT(SC), .SIGNED_IN(SIN)) dut (
    .clk_audio(clk_audio), .reset_n(reset_n), .in_data(in_data), .route_l(route_l), .route_r(route_r),
    .atten(atten), .mute(mute), .audio_l(audio_l), .audio_r(audio_r), .sample_stb(sample_stb),
    .sat_flag(sat_flag));

  always #5 clk_audio = ~clk_audio;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int conv(input int v, input int att);
    int u;
    if (SIN != 0) u = (v >= (1 << (IW-1))) ? v - (1 << IW) : v;
    else          u = v - (1 << (IW-1));
    return (u * (1 << (OW-IW))) >>> att;
  endfunction

  function automatic int clampv(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  int  hist [CH][SC];   // last SC samples taken, index 0 newest
  int  held_m [CH];
  int  sums_l [8], sums_r [8];
  bit  acc [8];
  int  n = 16;
  int  exp_l = 0, exp_r = 0;
  bit  exp_stb = 0, exp_sat = 0, mute_prev = 0;

  always @(posedge clk_audio) begin
    int  sl, sr, c, nh [CH];
    bit  any, same;
    if (!reset_n) begin
      for (int k = 0; k < CH; k++) begin
        held_m[k] = 0;
        for (int j = 0; j < SC; j++) hist[k][j] = 0;
      end
      for (int i = 0; i < 8; i++) begin sums_l[i] = 0; sums_r[i] = 0; acc[i] = 0; end
      exp_l = 0; exp_r = 0; exp_stb = 0; exp_sat = 0; mute_prev = 0;
    end else begin
      sl = 0; sr = 0; any = 0;
      for (int k = 0; k < CH; k++) begin
        c = conv(held_m[k], int'(atten[2*k +: 2]));
        if (route_l[k]) sl += c;
        if (route_r[k]) sr += c;
        same = 1;
        for (int j = 1; j < SC; j++) if (hist[k][j] != hist[k][0]) same = 0;
        nh[k] = held_m[k];
        if (same && hist[k][SC-1] != held_m[k]) begin any = 1; nh[k] = hist[k][SC-1]; end
      end
      sums_l[n % 8] = sl; sums_r[n % 8] = sr; acc[n % 8] = any;
      for (int k = 0; k < CH; k++) begin
        held_m[k] = nh[k];
        for (int j = SC-1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = int'(in_data[k*IW +: IW]);
      end
      // A value accepted at edge e reaches the output at edge e+2, using the mix formed at edge e+1.
      if (mute) begin
        exp_l = 0; exp_r = 0; exp_stb = !mute_prev;
      end else if (acc[(n + 6) % 8] || mute_prev) begin
        exp_l = clampv(sums_l[(n + 7) % 8]);
        exp_r = clampv(sums_r[(n + 7) % 8]);
        if (exp_l != sums_l[(n + 7) % 8] || exp_r != sums_r[(n + 7) % 8]) exp_sat = 1;
        exp_stb = 1;
      end else begin
        exp_stb = 0;
      end
      mute_prev = mute;
    end
    n++;
  end

  always @(negedge clk_audio) begin
    if (chk_en) begin
      chk("cyc_stb", int'(sample_stb), int'(exp_stb));
      chk("cyc_audio_l", int'(audio_l), exp_l);
      chk("cyc_audio_r", int'(audio_r), exp_r);
      chk("cyc_sat", int'(sat_flag), int'(exp_sat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input int k, input int v);
    in_data[k*IW +: IW] = IW'(v);
  endtask

  task automatic count_stb(input int cycles, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int e = 1; e <= cycles; e++) begin
      @(negedge clk_audio);
      if (sample_stb) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
  endtask

  int cnt, first;

  initial begin
    reset_n = 0; in_data = '0; route_l = 2'b01; route_r = 2'b01; atten = '0; mute = 0;
    repeat (3) @(negedge clk_audio);
    chk_en = 1;
    chk("reset_audio_l", int'(audio_l), 0);
    chk("reset_stb", int'(sample_stb), 0);
    chk("reset_sat", int'(sat_flag), 0);
    reset_n = 1;

    // ch0 0x000 -> 0x400: output 0 at edge 5 with a single strobe
    set_ch(0, 'h400);
    count_stb(8, cnt, first);
    $display("txn t1 stb_count=%0d first_edge=%0d audio_l=%0d", cnt, first, audio_l);
    chk("t1_stb_count", cnt, 1);
    chk("t1_stb_edge", first, 5);
    chk("t1_audio_l", int'(audio_l), 0);

    // toggling input never accepted
    for (int i = 0; i < 20; i++) begin
      set_ch(0, (i % 2) ? 'h7FF : 'h000);
      @(negedge clk_audio);
      if (sample_stb) cnt++;
    end
    set_ch(0, 'h400);
    count_stb(6, cnt, first);
    $display("txn t2 stb_count=%0d audio_l=%0d", cnt, audio_l);
    chk("t2_no_stb", cnt, 0);
    chk("t2_audio_l", int'(audio_l), 0);

    // attenuated full-scale negative, no saturation
    atten = 4'b0001;
    @(negedge clk_audio);
    set_ch(0, 'h000);
    repeat (7) @(negedge clk_audio);
    $display("txn t4 audio_l=%0d audio_r=%0d sat=%0d", audio_l, audio_r, sat_flag);
    chk("t4_audio_l", int'(audio_l), -16384);
    chk("t4_audio_r", int'(audio_r), -16384);
    chk("t4_model_l", exp_l, -16384);
    chk("t4_sat", int'(sat_flag), 0);

    // mute and release
    mute = 1;
    count_stb(4, cnt, first);
    $display("txn t5a stb_count=%0d audio_l=%0d", cnt, audio_l);
    chk("t5_mute_stb", cnt, 1);
    chk("t5_mute_first", first, 1);
    chk("t5_mute_l", int'(audio_l), 0);
    mute = 0;
    @(negedge clk_audio);
    $display("txn t5b stb=%0d audio_l=%0d", sample_stb, audio_l);
    chk("t5_release_stb", int'(sample_stb), 1);
    chk("t5_release_l", int'(audio_l), -16384);

    // two full-scale channels on left saturate
    atten = '0; route_l = 2'b11; route_r = 2'b00;
    @(negedge clk_audio);
    set_ch(0, 'h7FF); set_ch(1, 'h7FF);
    count_stb(7, cnt, first);
    $display("txn t3 stb_count=%0d audio_l=%0d audio_r=%0d sat=%0d", cnt, audio_l, audio_r, sat_flag);
    chk("t3_stb_count", cnt, 1);
    chk("t3_audio_l", int'(audio_l), 32767);
    chk("t3_model_l", exp_l, 32767);
    chk("t3_audio_r", int'(audio_r), 0);
    chk("t3_sat", int'(sat_flag), 1);

    // reset with a change pending
    set_ch(0, 'h123);
    @(negedge clk_audio);
    reset_n = 0;
    @(negedge clk_audio);
    reset_n = 1;
    chk("t6_audio_l", int'(audio_l), 0);
    chk("t6_sat", int'(sat_flag), 0);
    count_stb(7, cnt, first);
    $display("txn t6 stb_count=%0d first_edge=%0d", cnt, first);
    chk("t6_stb_count", cnt, 1);
    chk("t6_stb_edge", first, 5);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 29) == 0) begin
        route_l = CH'($urandom); route_r = CH'($urandom); atten = (2*CH)'($urandom);
      end
      if ($urandom_range(0, 24) == 0) mute = ~mute;
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 3) == 0) set_ch(k, int'($urandom_range(0, 2047)));
      end
      @(negedge clk_audio);
      if (i % 100 == 0)
        $display("txn rnd%0d audio_l=%0d audio_r=%0d stb=%0d sat=%0d", i, audio_l, audio_r, sample_stb, sat_flag);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
